// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage hazard detector for an in-order MIPS-style pipe.
//               Tracks the GPR writers in flight in stages E..last (DEPTH
//               entries of {valid, dst, tnew}).  Stalls the D-stage
//               instruction when a source register is still being produced
//               later than that instruction needs it.  When
//               SCOREBOARD_MD_EN is defined, it also models a multi-cycle
//               multiply/divide unit.  In that build an HI/LO access stalls
//               while the unit is busy.
// Macro       : SCOREBOARD_MD_EN - enables the mult/div busy counter.
// Ports       :
//   clk                    rising-edge clock
//   reset                  asynchronous active-high reset
//   D_valid                D-stage instruction is real (not a bubble)
//   D_rs, D_rt             D-stage source registers
//   D_Tuse_RS, D_Tuse_RT   cycles until each source is needed (all-ones = unused)
//   D_RegWrite, D_Dst      D-stage GPR write enable and destination
//   D_Tnew                 cycles until the D-stage result is available
//   D_isHILO               D-stage instruction touches HI/LO
//   D_md_start, D_md_div   D-stage issues mult/multu (0) or div/divu (1)
//   flush                  synchronous pipeline clear (exception/eret)
//   stall                  hold F/D, bubble into E
//   stall_rs/rt/md         stall cause breakdown
//   md_busy                multiply/divide unit occupied
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH   = 3,
    parameter int TW      = 3,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          D_valid,
    input  logic [4:0]    D_rs,
    input  logic [4:0]    D_rt,
    input  logic [TW-1:0] D_Tuse_RS,
    input  logic [TW-1:0] D_Tuse_RT,
    input  logic          D_RegWrite,
    input  logic [4:0]    D_Dst,
    input  logic [TW-1:0] D_Tnew,
    input  logic          D_isHILO,
    input  logic          D_md_start,
    input  logic          D_md_div,
    input  logic          flush,
    output logic          stall,
    output logic          stall_rs,
    output logic          stall_rt,
    output logic          stall_md,
    output logic          md_busy
);

    localparam logic [TW-1:0] C_TUSE_NONE = '1;

    // Entry 0 is the E stage, entry DEPTH-1 the last tracked stage.
    logic          r_vld  [DEPTH];
    logic [4:0]    r_dst  [DEPTH];
    logic [TW-1:0] r_tnew [DEPTH];

    logic w_hit_rs;
    logic w_hit_rt;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Hazard detection: a producer blocks the consumer while its result
    // needs more cycles than the consumer can wait.
    // ------------------------------------------------------------------
    always_comb begin
        w_hit_rs = 1'b0;
        w_hit_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_dst[i] == D_rs) && (r_tnew[i] > D_Tuse_RS))
                w_hit_rs = 1'b1;
            if (r_vld[i] && (r_dst[i] == D_rt) && (r_tnew[i] > D_Tuse_RT))
                w_hit_rt = 1'b1;
        end
    end

    // $0 is never recorded, but the D_rs/D_rt != 0 terms keep $0 harmless
    // even if that invariant were ever broken upstream.
    assign stall_rs = D_valid && (D_rs != 5'd0) && (D_Tuse_RS != C_TUSE_NONE) && w_hit_rs;
    assign stall_rt = D_valid && (D_rt != 5'd0) && (D_Tuse_RT != C_TUSE_NONE) && w_hit_rt;
    assign stall    = stall_rs | stall_rt | stall_md;

    // ------------------------------------------------------------------
    // Tracked pipeline.  Flush wins over both the stall bubble and the
    // D capture.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i]  <= 1'b0;
                r_dst[i]  <= 5'd0;
                r_tnew[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_dst[i]  <= r_dst[i-1];
                r_tnew[i] <= sat_dec(r_tnew[i-1]);
            end
            if (stall) begin
                r_vld[0] <= 1'b0;
            end else begin
                r_vld[0]  <= D_valid && D_RegWrite && (D_Dst != 5'd0);
                r_dst[0]  <= D_Dst;
                r_tnew[0] <= sat_dec(D_Tnew);
            end
        end
    end

    // ------------------------------------------------------------------
    // Multiply/divide occupancy
    // ------------------------------------------------------------------
`ifdef SCOREBOARD_MD_EN
    localparam int MW = $clog2(DIV_CYC + 1);

    logic [MW-1:0] r_md_cnt;

    // The counter survives flush: the unit keeps computing even when the
    // issuing instruction's successors are squashed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (D_valid && D_md_start && !stall) begin
            r_md_cnt <= D_md_div ? MW'(DIV_CYC) : MW'(MUL_CYC);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MW'(1);
        end
    end

    assign md_busy  = (r_md_cnt != '0);
    assign stall_md = D_valid && D_isHILO && md_busy;
`else
    logic w_unused_md;
    assign w_unused_md = D_isHILO ^ D_md_start ^ D_md_div ^ (MUL_CYC != DIV_CYC);
    assign md_busy  = 1'b0;
    assign stall_md = 1'b0;
`endif

endmodule
`default_nettype wire
